// File: rtl/sa_aw_channel.sv
// sa_aw_channel: per-slave AW round-robin arbiter with a registered AW output and WDATA order-FIFO push.
module sa_aw_channel #(
  parameter int MST_AMT          = 3,
  parameter int MST_ID_W         = $clog2(MST_AMT),
  parameter int TRANS_MST_ID_W   = 5,
  parameter int TRANS_SLV_ID_W   = MST_ID_W + TRANS_MST_ID_W,
  parameter int ADDR_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 3
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AWADDR_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AWLEN_i,
  input  logic [MST_AMT-1:0]                    dsp_AWVALID_i,
  input  logic [MST_AMT-1:0]                    dsp_slv_sel_i,
  output logic [MST_AMT-1:0]                    dsp_AWREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]             s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
  output logic                                  s_AWVALID_o,
  input  logic                                  s_AWREADY_i,
  output logic [MST_ID_W-1:0]                   AW_mst_id_o,
  output logic [TRANS_DATA_LEN_W-1:0]           AW_AxLEN_o,
  output logic                                  AW_fifo_order_wr_en_o,
  input  logic                                  AW_stall_i
);
  logic [MST_AMT-1:0]          w_req;
  logic [MST_ID_W-1:0]         w_grant;
  logic [TRANS_MST_ID_W-1:0]   w_id;
  logic [ADDR_WIDTH-1:0]       w_addr;
  logic [TRANS_DATA_LEN_W-1:0] w_len;
  logic                        w_load_en;
  logic [MST_ID_W-1:0]         r_rr_ptr;
  logic                        r_valid;
  logic [TRANS_SLV_ID_W-1:0]   r_id;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [TRANS_DATA_LEN_W-1:0] r_len;
  assign w_req     = dsp_AWVALID_i & dsp_slv_sel_i;
  assign w_load_en = (~r_valid | s_AWREADY_i) & ~AW_stall_i & |w_req;
  // Lowest requester at or above the pointer wins; below-pointer requesters only when none above.
  always_comb begin
    w_grant = '0;
    for (int m = MST_AMT - 1; m >= 0; m--)
      if (w_req[m] && MST_ID_W'(m) < r_rr_ptr) w_grant = MST_ID_W'(m);
    for (int m = MST_AMT - 1; m >= 0; m--)
      if (w_req[m] && MST_ID_W'(m) >= r_rr_ptr) w_grant = MST_ID_W'(m);
  end
  always_comb begin
    w_id   = '0;
    w_addr = '0;
    w_len  = '0;
    for (int m = 0; m < MST_AMT; m++)
      if (w_grant == MST_ID_W'(m)) begin
        w_id   = dsp_AWID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        w_addr = dsp_AWADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        w_len  = dsp_AWLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      end
  end
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_rr_ptr <= '0;
    end else if (w_load_en) begin
      r_valid  <= 1'b1;
      r_id     <= {w_grant, w_id};
      r_addr   <= w_addr;
      r_len    <= w_len;
      r_rr_ptr <= (w_grant == MST_ID_W'(MST_AMT - 1)) ? '0 : w_grant + 1'b1;
    end else if (s_AWREADY_i) begin
      r_valid  <= 1'b0;
    end
  end
  assign dsp_AWREADY_o         = w_load_en ? (MST_AMT'(1) << w_grant) : '0;
  assign AW_fifo_order_wr_en_o = w_load_en;
  assign AW_mst_id_o           = w_grant;
  assign AW_AxLEN_o            = w_len;
  assign s_AWVALID_o           = r_valid;
  assign s_AWID_o              = r_id;
  assign s_AWADDR_o            = r_addr;
  assign s_AWLEN_o             = r_len;
endmodule

// File: tb/tb_sa_aw_channel.sv
// tb_sa_aw_channel: directed self-checking bench for the per-slave AW arbiter.
module tb_sa_aw_channel;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_t [3];
  logic [31:0] ad_t [3];
  logic [2:0]  ln_t [3];
  logic [2:0]  valid, sel, awready;
  logic [6:0]  s_id;
  logic [31:0] s_addr;
  logic [2:0]  s_len, axlen;
  logic        s_valid, s_ready, wr_en, stall;
  logic [1:0]  mst_id;
  int          checks = 0, failures = 0, pushes = 0;
  logic [1:0]  gseq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  sa_aw_channel dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .dsp_AWID_i({id_t[2], id_t[1], id_t[0]}),
    .dsp_AWADDR_i({ad_t[2], ad_t[1], ad_t[0]}),
    .dsp_AWLEN_i({ln_t[2], ln_t[1], ln_t[0]}),
    .dsp_AWVALID_i(valid), .dsp_slv_sel_i(sel), .dsp_AWREADY_o(awready),
    .s_AWID_o(s_id), .s_AWADDR_o(s_addr), .s_AWLEN_o(s_len),
    .s_AWVALID_o(s_valid), .s_AWREADY_i(s_ready),
    .AW_mst_id_o(mst_id), .AW_AxLEN_o(axlen),
    .AW_fifo_order_wr_en_o(wr_en), .AW_stall_i(stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (wr_en) pushes <= pushes + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; valid = 0; sel = 3'b111; s_ready = 1; stall = 0;
    id_t = '{5'h01, 5'h0A, 5'h1F};
    ad_t = '{32'h100, 32'h1000, 32'h2000};
    ln_t = '{3'd0, 3'd3, 3'd7};
    cyc(); cyc();
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wren", 32'(wr_en), 0);
    chk("rst_saddr", s_addr, 0);
    rst = 0;
    cyc();
    valid = 3'b010;
    #2;
    chk("m1_awready", 32'(awready), 32'b010);
    chk("m1_wren", 32'(wr_en), 1);
    chk("m1_mstid", 32'(mst_id), 1);
    chk("m1_axlen", 32'(axlen), 3);
    cyc();
    valid = 3'b000;
    chk("m1_svalid", 32'(s_valid), 1);
    chk("m1_sid", 32'(s_id), 32'h2A);
    chk("m1_saddr", s_addr, 32'h1000);
    chk("m1_slen", 32'(s_len), 3);
    #2;
    chk("idle_awready", 32'(awready), 0);
    chk("idle_wren", 32'(wr_en), 0);
    cyc();
    chk("drain_svalid", 32'(s_valid), 0);
    rst = 1;
    cyc();
    rst = 0;
    pushes = 0;
    valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_awready", 32'(awready), 32'(3'b001 << gseq[i]));
      chk("rr_mstid", 32'(mst_id), 32'(gseq[i]));
      cyc();
      chk("rr_sid", 32'(s_id), 32'({gseq[i], id_t[gseq[i]]}));
      chk("rr_saddr", s_addr, ad_t[gseq[i]]);
    end
    chk("rr_pushes", 32'(pushes), 4);
    s_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_awready", 32'(awready), 0);
      chk("bp_wren", 32'(wr_en), 0);
      cyc();
      chk("bp_svalid", 32'(s_valid), 1);
      chk("bp_sid", 32'(s_id), 32'h01);
      chk("bp_saddr", s_addr, 32'h100);
    end
    s_ready = 1;
    #2;
    chk("bp_rel_awready", 32'(awready), 32'b010);
    cyc();
    chk("bp_rel_saddr", s_addr, 32'h1000);
    valid = 3'b101;
    stall = 1;
    #2;
    chk("st_awready", 32'(awready), 0);
    chk("st_wren", 32'(wr_en), 0);
    cyc();
    chk("st_drain_svalid", 32'(s_valid), 0);
    #2;
    chk("st_hold_awready", 32'(awready), 0);
    cyc();
    chk("st_hold_svalid", 32'(s_valid), 0);
    stall = 0;
    #2;
    chk("st_rel_awready", 32'(awready), 32'b100);
    chk("st_rel_mstid", 32'(mst_id), 2);
    chk("st_rel_axlen", 32'(axlen), 7);
    cyc();
    chk("st_rel_svalid", 32'(s_valid), 1);
    chk("st_rel_saddr", s_addr, 32'h2000);
    valid = 3'b101;
    sel = 3'b100;
    #2;
    chk("sel_awready", 32'(awready), 32'b100);
    chk("sel_mstid", 32'(mst_id), 2);
    cyc();
    chk("sel_sid", 32'(s_id), 32'h5F);
    valid = 3'b000;
    s_ready = 0;
    rst = 1;
    #2;
    chk("rstmid_wren", 32'(wr_en), 0);
    cyc();
    chk("rstmid_svalid", 32'(s_valid), 0);
    chk("rstmid_saddr", s_addr, 0);
    rst = 0;
    #2;
    chk("rstmid_awready", 32'(awready), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sa_aw_channel.md
Name: sa_aw_channel

Overview:
- Per-slave write-address arbiter of the AXI4 interconnect.
- Collects AW requests from MST_AMT dispatchers, selects one by round-robin, and drives a single registered AW channel to the slave.
- Directly feeds the downstream WDATA channel stage with ordering info (master index, AxLEN, push strobe) and honours that stage's stall.

Parameters:
MST_AMT, 3, number of masters (dispatchers) competing for this slave
MST_ID_W, $clog2(MST_AMT), width of master index
TRANS_MST_ID_W, 5, width of AWID as issued by a master
TRANS_SLV_ID_W, MST_ID_W+TRANS_MST_ID_W, width of AWID toward slave ({master index, AWID})
ADDR_WIDTH, 32, address width
TRANS_DATA_LEN_W, 3, width of AWLEN

Ports:
ACLK_i  in  1  clock
ARESET_i  in  1  synchronous active-high reset
dsp_AWID_i  in  TRANS_MST_ID_W*MST_AMT  per-master AWID, master m at slice m
dsp_AWADDR_i  in  ADDR_WIDTH*MST_AMT  per-master AWADDR
dsp_AWLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master AWLEN
dsp_AWVALID_i  in  MST_AMT  per-master AWVALID
dsp_slv_sel_i  in  MST_AMT  1 = master m's current AW targets this slave
dsp_AWREADY_o  out  MST_AMT  per-master AWREADY
s_AWID_o  out  TRANS_SLV_ID_W  {granted master index, AWID}
s_AWADDR_o  out  ADDR_WIDTH  address to slave
s_AWLEN_o  out  TRANS_DATA_LEN_W  burst length to slave
s_AWVALID_o  out  1  AWVALID to slave
s_AWREADY_i  in  1  AWREADY from slave
AW_mst_id_o  out  MST_ID_W  granted master index, for WDATA order FIFO
AW_AxLEN_o  out  TRANS_DATA_LEN_W  granted AWLEN, for WDATA order FIFO
AW_fifo_order_wr_en_o  out  1  order FIFO push strobe
AW_stall_i  in  1  WDATA order FIFO full; blocks new acceptance

Behaviour:
- Clocking and reset: single clock ACLK_i. ARESET_i is synchronous and active-high. On reset, all s_* outputs are 0, rr_ptr = 0, dsp_AWREADY_o = 0, and AW_fifo_order_wr_en_o = 0.
- Requests: req[m] = dsp_AWVALID_i[m] & dsp_slv_sel_i[m]. A master with slv_sel = 0 is never granted and never sees AWREADY.
- Accept condition: load_en = (~s_AWVALID_o | s_AWREADY_i) & ~AW_stall_i & |req.
- Round-robin grant: combinational search starting at rr_ptr, ascending, wrapping MST_AMT-1 -> 0. The first m with req[m] wins; g = winner.
- On load_en, all of the following happen in the same cycle:
  - dsp_AWREADY_o[g] = 1 (one-hot, all others 0). dsp_AWREADY_o is all-zero when load_en = 0.
  - AW_fifo_order_wr_en_o = 1, with AW_mst_id_o = g and AW_AxLEN_o = dsp_AWLEN_i[g]. The push happens exactly once per accepted AW.
  - Next edge: s_AWVALID_o <= 1, s_AWID_o <= {g, dsp_AWID_i[g]}, s_AWADDR_o <= dsp_AWADDR_i[g], s_AWLEN_o <= dsp_AWLEN_i[g], rr_ptr <= (g == MST_AMT-1) ? 0 : g+1.
- Latency: 1 cycle from dispatcher handshake to s_AWVALID_o.
- Throughput: 1 AW per cycle when s_AWREADY_i stays high.
- Slave handshake (s_AWVALID_o & s_AWREADY_i) without a new accept clears s_AWVALID_o next edge. Payload registers hold their values; they are don't-care while invalid.
- Backpressure: while s_AWVALID_o = 1 and s_AWREADY_i = 0, the payload is held stable (AXI rule) and no new accept occurs.
- Stall: AW_stall_i = 1 blocks acceptance even if the output register is free. A pending s_AWVALID_o may still complete its slave handshake. rr_ptr does not move.
- AW_mst_id_o and AW_AxLEN_o are don't-care when the strobe is 0. They are driven from the grant mux.
- Reset mid-burst drops any held AW. No order push is issued for it.

Test Plan:
- Reset -> s_AWVALID_o = 0, dsp_AWREADY_o = 3'b000, AW_fifo_order_wr_en_o = 0, AW_mst_id_o don't-care.
- M1 alone: valid, sel = 1, AWID = 5'h0A, ADDR = 0x1000, LEN = 3, s_AWREADY_i = 1 -> same cycle: dsp_AWREADY_o = 3'b010, wr_en = 1, AW_mst_id_o = 1, AW_AxLEN_o = 3. Next cycle: s_AWVALID_o = 1, s_AWID_o = {2'd1, 5'h0A}, s_AWADDR_o = 0x1000.
- All three masters request continuously, s_AWREADY_i = 1 -> grants 0, 1, 2, 0 on consecutive cycles; 4 order pushes.
- s_AWREADY_i = 0 for 3 cycles with M0 holding -> s_AW* held stable, dsp_AWREADY_o = 0. On READY = 1, accept of the next pending master happens the same cycle as the slave handshake.
- AW_stall_i = 1 with M2 requesting and output empty -> no AWREADY, no push, rr_ptr unchanged. Stall drop -> M2 accepted next cycle.
- M0 valid with sel = 0 and M2 valid with sel = 1 -> only M2 granted. Reset asserted while s_AWVALID_o = 1 -> s_AWVALID_o = 0 next edge.
